ff_access_sequencer: RTL and testbench

FF_ACCESS_SEQUENCER -- requirements
Module: ff_access_sequencer

---
 rtl/ff_seq_pkg.sv | 27 ++
 rtl/rr_arb2.sv | 29 ++
 rtl/ff_access_sequencer.sv | 156 +++++++++++++++
 tb/tb_ff_access_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ff_seq_pkg.sv
// Shared types and constants for the dual flip-flop access sequencer.
// Op-codes, FSM states and the latched access descriptor live here.
package ff_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        DONE
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SET  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;
    localparam logic [1:0] OP_TOG  = 2'b11;

    localparam int PULSE_W_DEF = 2;

    // One access as captured at grant time.
    typedef struct packed {
        logic [1:0] op;
        logic       sel;
        logic       dat;
    } acc_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a one-hot combinational grant.
// Priority moves to the loser whenever an advance strobe accompanies a grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       adv,
    output logic [1:0] gnt
);

    logic prio_b;

    always_comb begin
        gnt = 2'b00;
        if (req_a && (!req_b || !prio_b))
            gnt[0] = 1'b1;
        else if (req_b)
            gnt[1] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            prio_b <= 1'b0;
        else if (adv && (gnt != 2'b00))
            prio_b <= gnt[0];
    end

endmodule

// File: rtl/ff_access_sequencer.sv
// Sequences LOAD/SET/CLEAR/TOGGLE accesses from two requesters onto two external
// flip-flops, generating registered D, clock and async set/reset strobes.
module ff_access_sequencer
    import ff_seq_pkg::*;
#(
    parameter int PULSE_W = PULSE_W_DEF
) (
    input  logic       CP,
    input  logic       MR,
    input  logic       REQ_A,
    input  logic       REQ_B,
    input  logic [1:0] OP_A,
    input  logic [1:0] OP_B,
    input  logic       SEL_A,
    input  logic       SEL_B,
    input  logic       DAT_A,
    input  logic       DAT_B,
    output logic       GNT_A,
    output logic       GNT_B,
    output logic       DONE_A,
    output logic       DONE_B,
    output logic       RDATA,
    input  logic       Q1,
    input  logic       Q2,
    output logic       FCP1,
    output logic       FCP2,
    output logic       FD1,
    output logic       FD2,
    output logic       FSD1,
    output logic       FSD2,
    output logic       FRD1,
    output logic       FRD2
);

    localparam logic [3:0] CNT_INIT = 4'(PULSE_W - 1);

    state_t     state, state_d;
    acc_t       acc, acc_d, req_sel;
    logic       who, who_d;
    logic [3:0] cnt, cnt_d;
    logic [1:0] fcp, fcp_d, fd, fd_d, fsd_n, fsd_d, frd_n, frd_d;
    logic [1:0] gnt, gnt_d, done, done_d;
    logic       rdata, rdata_d;
    logic [1:0] q;
    logic [1:0] arb_gnt;
    logic       adv;

    assign q = {Q2, Q1};

    rr_arb2 u_arb (
        .clk   (CP),
        .rst   (MR),
        .req_a (REQ_A),
        .req_b (REQ_B),
        .adv   (adv),
        .gnt   (arb_gnt)
    );

    always_comb begin
        req_sel = arb_gnt[1] ? acc_t'{OP_B, SEL_B, DAT_B} : acc_t'{OP_A, SEL_A, DAT_A};
    end

    always_comb begin
        state_d = state;
        acc_d   = acc;
        who_d   = who;
        cnt_d   = cnt;
        fcp_d   = fcp;
        fd_d    = fd;
        fsd_d   = fsd_n;
        frd_d   = frd_n;
        gnt_d   = 2'b00;
        done_d  = 2'b00;
        rdata_d = rdata;
        adv     = 1'b0;
        case (state)
            IDLE: begin
                if (arb_gnt != 2'b00) begin
                    adv     = 1'b1;
                    acc_d   = req_sel;
                    who_d   = arb_gnt[1];
                    gnt_d   = arb_gnt;
                    state_d = SETUP;
                    // D is set up here so it is stable for the whole SETUP cycle.
                    if (req_sel.op == OP_LOAD)
                        fd_d[req_sel.sel] = req_sel.dat;
                    else if (req_sel.op == OP_TOG)
                        fd_d[req_sel.sel] = ~q[req_sel.sel];
                end
            end
            SETUP: begin
                state_d = PULSE;
                cnt_d   = CNT_INIT;
                case (acc.op)
                    OP_SET:  fsd_d[acc.sel] = 1'b0;
                    OP_CLR:  frd_d[acc.sel] = 1'b0;
                    default: fcp_d[acc.sel] = 1'b1;
                endcase
            end
            PULSE: begin
                if (cnt == 4'd0) begin
                    state_d = HOLD;
                    fcp_d   = 2'b00;
                    fsd_d   = 2'b11;
                    frd_d   = 2'b11;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            HOLD: begin
                state_d      = DONE;
                done_d[who]  = 1'b1;
                rdata_d      = q[acc.sel];
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            state <= IDLE;
            acc   <= '0;
            who   <= 1'b0;
            cnt   <= 4'd0;
            fcp   <= 2'b00;
            fd    <= 2'b00;
            fsd_n <= 2'b11;
            frd_n <= 2'b11;
            gnt   <= 2'b00;
            done  <= 2'b00;
            rdata <= 1'b0;
        end else begin
            state <= state_d;
            acc   <= acc_d;
            who   <= who_d;
            cnt   <= cnt_d;
            fcp   <= fcp_d;
            fd    <= fd_d;
            fsd_n <= fsd_d;
            frd_n <= frd_d;
            gnt   <= gnt_d;
            done  <= done_d;
            rdata <= rdata_d;
        end
    end

    assign {GNT_B, GNT_A}   = gnt;
    assign {DONE_B, DONE_A} = done;
    assign RDATA            = rdata;
    assign {FCP2, FCP1}     = fcp;
    assign {FD2, FD1}       = fd;
    assign {FSD2, FSD1}     = fsd_n;
    assign {FRD2, FRD1}     = frd_n;

endmodule

// File: tb/tb_ff_access_sequencer.sv
// Self-checking bench: randomized accesses against a dual flip-flop model and
// an access-level reference of expected Q, priority, latency and strobe width.
module tb_ff_access_sequencer;
    import ff_seq_pkg::*;

    localparam int PW = 2;

    logic       CP, MR;
    logic       REQ_A, REQ_B, SEL_A, SEL_B, DAT_A, DAT_B;
    logic [1:0] OP_A, OP_B;
    logic       GNT_A, GNT_B, DONE_A, DONE_B, RDATA;
    logic       Q1, Q2, FCP1, FCP2, FD1, FD2, FSD1, FSD2, FRD1, FRD2;

    logic       wreq;
    logic       w1_gnt_a, w1_gnt_b, w1_done_a, w1_done_b, w1_rdata;
    logic       w1_fcp1, w1_fcp2, w1_fd1, w1_fd2, w1_fsd1, w1_fsd2, w1_frd1, w1_frd2;
    logic       w15_gnt_a, w15_gnt_b, w15_done_a, w15_done_b, w15_rdata;
    logic       w15_fcp1, w15_fcp2, w15_fd1, w15_fd2, w15_fsd1, w15_fsd2, w15_frd1, w15_frd2;

    int checks = 0;
    int failures = 0;

    bit exp_q [2];
    bit fd_model [2];
    bit prio_b;
    bit last_rdata;

    logic q1, q2, ff_clr;

    initial CP = 1'b0;
    always #5 CP = ~CP;

    ff_access_sequencer #(.PULSE_W(PW)) dut (
        .CP(CP), .MR(MR), .REQ_A(REQ_A), .REQ_B(REQ_B), .OP_A(OP_A), .OP_B(OP_B),
        .SEL_A(SEL_A), .SEL_B(SEL_B), .DAT_A(DAT_A), .DAT_B(DAT_B),
        .GNT_A(GNT_A), .GNT_B(GNT_B), .DONE_A(DONE_A), .DONE_B(DONE_B), .RDATA(RDATA),
        .Q1(Q1), .Q2(Q2), .FCP1(FCP1), .FCP2(FCP2), .FD1(FD1), .FD2(FD2),
        .FSD1(FSD1), .FSD2(FSD2), .FRD1(FRD1), .FRD2(FRD2)
    );

    ff_access_sequencer #(.PULSE_W(1)) dut_w1 (
        .CP(CP), .MR(MR), .REQ_A(wreq), .REQ_B(1'b0), .OP_A(OP_LOAD), .OP_B(OP_LOAD),
        .SEL_A(1'b0), .SEL_B(1'b0), .DAT_A(1'b1), .DAT_B(1'b0),
        .GNT_A(w1_gnt_a), .GNT_B(w1_gnt_b), .DONE_A(w1_done_a), .DONE_B(w1_done_b),
        .RDATA(w1_rdata), .Q1(1'b0), .Q2(1'b0), .FCP1(w1_fcp1), .FCP2(w1_fcp2),
        .FD1(w1_fd1), .FD2(w1_fd2), .FSD1(w1_fsd1), .FSD2(w1_fsd2),
        .FRD1(w1_frd1), .FRD2(w1_frd2)
    );

    ff_access_sequencer #(.PULSE_W(15)) dut_w15 (
        .CP(CP), .MR(MR), .REQ_A(wreq), .REQ_B(1'b0), .OP_A(OP_LOAD), .OP_B(OP_LOAD),
        .SEL_A(1'b0), .SEL_B(1'b0), .DAT_A(1'b1), .DAT_B(1'b0),
        .GNT_A(w15_gnt_a), .GNT_B(w15_gnt_b), .DONE_A(w15_done_a), .DONE_B(w15_done_b),
        .RDATA(w15_rdata), .Q1(1'b0), .Q2(1'b0), .FCP1(w15_fcp1), .FCP2(w15_fcp2),
        .FD1(w15_fd1), .FD2(w15_fd2), .FSD1(w15_fsd1), .FSD2(w15_fsd2),
        .FRD1(w15_frd1), .FRD2(w15_frd2)
    );

    // Dual D flip-flop with async active-low set/reset; set wins if both low.
    always @(posedge FCP1 or negedge FSD1 or negedge FRD1 or posedge ff_clr)
        if (ff_clr) q1 <= 1'b0;
        else if (!FSD1) q1 <= 1'b1;
        else if (!FRD1) q1 <= 1'b0;
        else q1 <= FD1;

    always @(posedge FCP2 or negedge FSD2 or negedge FRD2 or posedge ff_clr)
        if (ff_clr) q2 <= 1'b0;
        else if (!FSD2) q2 <= 1'b1;
        else if (!FRD2) q2 <= 1'b0;
        else q2 <= FD2;

    assign Q1 = q1;
    assign Q2 = q2;

    function automatic logic [3:0] pins(input bit s);
        return s ? {FCP2, FD2, FSD2, FRD2} : {FCP1, FD1, FSD1, FRD1};
    endfunction

    task automatic wait_grant(output bit who, output bit ok);
        bit seen = 0;
        who = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge CP); #1;
            if (GNT_A || GNT_B) begin
                seen = 1;
                who  = GNT_B;
                checks++;
                if (GNT_A && GNT_B) begin
                    failures++;
                    $display("FAIL gnt_exclusive: GNT_A=%b GNT_B=%b, required one-hot", GNT_A, GNT_B);
                end
            end
        end
        ok = seen;
        if (!seen) begin
            checks++; failures++;
            $display("FAIL grant_timeout: no grant within 40 cycles");
        end
    endtask

    // Follows one access from the grant sample through DONE.
    task automatic track(input bit who, input logic [1:0] op, input bit sel, input bit dat);
        int n, strobes = 0, wrong = 0, static_err = 0, hold_err = 0, done_n = -1;
        bit newq, got = 0;
        logic [3:0] p, pa, pb, nt0;
        case (op)
            OP_LOAD: newq = dat;
            OP_SET:  newq = 1'b1;
            OP_CLR:  newq = 1'b0;
            default: newq = ~exp_q[sel];
        endcase
        if (op == OP_LOAD) fd_model[sel] = dat;
        else if (op == OP_TOG) fd_model[sel] = ~exp_q[sel];
        p = pins(sel);
        checks++;
        if (p[2] !== fd_model[sel]) begin
            failures++;
            $display("FAIL setup_fd: op=%0d sel=%0d FD=%b, required %b", op, sel, p[2], fd_model[sel]);
        end
        nt0 = pins(~sel);
        prio_b = ~who;
        for (n = 1; n <= PW + 6 && !got; n++) begin
            @(posedge CP); #1;
            p = pins(sel); pa = pins(0); pb = pins(1);
            case (op)
                OP_SET: begin
                    if (!p[1]) strobes++;
                    if (p[3] || !p[0]) wrong++;
                end
                OP_CLR: begin
                    if (!p[0]) strobes++;
                    if (p[3] || !p[1]) wrong++;
                end
                default: begin
                    if (p[3]) strobes++;
                    if (!p[1] || !p[0]) wrong++;
                end
            endcase
            if ((!pa[1] && !pa[0]) || (!pb[1] && !pb[0])) wrong++;
            if (pins(~sel) !== nt0) static_err++;
            if (GNT_A || GNT_B) wrong++;
            if ((who ? DONE_B : DONE_A) === 1'b1) begin
                got = 1;
                done_n = n;
                if ((who ? DONE_A : DONE_B) !== 1'b0) wrong++;
                checks++;
                if (RDATA !== newq) begin
                    failures++;
                    $display("FAIL rdata: op=%0d sel=%0d RDATA=%b, required %b", op, sel, RDATA, newq);
                end
            end else begin
                if (RDATA !== last_rdata) hold_err++;
                if (DONE_A || DONE_B) wrong++;
            end
        end
        checks++;
        if (done_n != PW + 2) begin
            failures++;
            $display("FAIL done_latency: done after %0d edges, required %0d", done_n, PW + 2);
        end
        checks++;
        if (strobes != PW || wrong != 0) begin
            failures++;
            $display("FAIL strobe: op=%0d width=%0d stray=%0d, required width %0d stray 0", op, strobes, wrong, PW);
        end
        checks++;
        if (static_err != 0 || hold_err != 0) begin
            failures++;
            $display("FAIL static: non-target changes=%0d rdata changes=%0d, required 0/0", static_err, hold_err);
        end
        exp_q[sel] = newq;
        last_rdata = newq;
    endtask

    task automatic access(input bit who, input logic [1:0] op, input bit sel, input bit dat);
        bit g, ok;
        if (!who) begin REQ_A = 1; OP_A = op; SEL_A = sel; DAT_A = dat; end
        else      begin REQ_B = 1; OP_B = op; SEL_B = sel; DAT_B = dat; end
        wait_grant(g, ok);
        REQ_A = 0; REQ_B = 0;
        // Post-grant input changes must not disturb the access.
        OP_A = 2'($urandom); SEL_A = 1'($urandom); DAT_A = 1'($urandom);
        OP_B = 2'($urandom); SEL_B = 1'($urandom); DAT_B = 1'($urandom);
        if (ok) begin
            checks++;
            if (g !== who) begin
                failures++;
                $display("FAIL grant_who: granted %0d, required %0d", g, who);
            end
            track(who, op, sel, dat);
        end
    endtask

    task automatic test_reset();
        MR = 1; #1;
        checks++;
        if ({GNT_A, GNT_B, DONE_A, DONE_B, RDATA, FCP1, FCP2, FD1, FD2, FSD1, FSD2, FRD1, FRD2}
            !== 13'b0000000001111) begin
            failures++;
            $display("FAIL reset_state: outputs=%b, required 0000000001111",
                     {GNT_A, GNT_B, DONE_A, DONE_B, RDATA, FCP1, FCP2, FD1, FD2, FSD1, FSD2, FRD1, FRD2});
        end
        ff_clr = 1; #1 ff_clr = 0;
        REQ_A = 1;
        repeat (3) @(posedge CP);
        #1;
        checks++;
        if (GNT_A !== 1'b0 || FCP1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: GNT_A=%b FCP1=%b under reset, required 0/0", GNT_A, FCP1);
        end
        REQ_A = 0;
        MR = 0;
        exp_q = '{0, 0}; fd_model = '{0, 0}; prio_b = 0; last_rdata = 0;
    endtask

    task automatic test_load();
        access(0, OP_LOAD, 0, 1);
        checks++;
        if (q1 !== 1'b1) begin
            failures++;
            $display("FAIL load_q1: Q1=%b, required 1", q1);
        end
    endtask

    task automatic test_set_clear();
        access(1, OP_SET, 1, 0);
        access(1, OP_CLR, 1, 1);
    endtask

    task automatic test_alternate();
        bit g, ok;
        REQ_A = 1; OP_A = OP_LOAD; SEL_A = 0; DAT_A = 0;
        REQ_B = 1; OP_B = OP_TOG;  SEL_B = 1; DAT_B = 0;
        for (int i = 0; i < 3; i++) begin
            bit want;
            want = prio_b;
            wait_grant(g, ok);
            if (!ok) break;
            checks++;
            if (g !== want) begin
                failures++;
                $display("FAIL alternate_who: grant %0d went to %0d, required %0d", i, g, want);
            end
            if (i == 2) begin REQ_A = 0; REQ_B = 0; end
            if (!g) track(0, OP_A, SEL_A, DAT_A);
            else    track(1, OP_B, SEL_B, DAT_B);
        end
        REQ_A = 0; REQ_B = 0;
    endtask

    task automatic test_toggle();
        access(0, OP_CLR, 0, 0);
        for (int i = 0; i < 3; i++) access(i[0], OP_TOG, 0, 0);
    endtask

    task automatic test_mr_abort();
        bit g, ok;
        int dn = 0;
        REQ_A = 1; OP_A = OP_SET; SEL_A = 0; DAT_A = 0;
        wait_grant(g, ok);
        REQ_A = 0;
        @(posedge CP); #1;
        checks++;
        if (FSD1 !== 1'b0) begin
            failures++;
            $display("FAIL abort_pulse: FSD1=%b in PULSE, required 0", FSD1);
        end
        #2 MR = 1; #1;
        checks++;
        if ({FSD1, FRD1, FCP1, FSD2, FRD2, FCP2, DONE_A, DONE_B, GNT_A, RDATA} !== 10'b1101100000) begin
            failures++;
            $display("FAIL abort_release: pins=%b, required 1101100000",
                     {FSD1, FRD1, FCP1, FSD2, FRD2, FCP2, DONE_A, DONE_B, GNT_A, RDATA});
        end
        @(posedge CP); #2 MR = 0;
        exp_q[0] = 1; fd_model = '{0, 0}; prio_b = 0; last_rdata = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CP); #1;
            if (DONE_A || DONE_B) dn++;
        end
        checks++;
        if (dn != 0) begin
            failures++;
            $display("FAIL abort_done: %0d DONE pulses after abort, required 0", dn);
        end
        access(0, OP_LOAD, 1, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++)
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic test_pulse_widths();
        int g1 = -1, d1 = -1, s1 = 0, g15 = -1, d15 = -1, s15 = 0;
        wreq = 1;
        for (int c = 0; c < 26; c++) begin
            @(posedge CP); #1;
            if (w1_gnt_a)  begin g1 = c; wreq = 0; end
            if (w15_gnt_a) g15 = c;
            if (w1_done_a)  d1 = c;
            if (w15_done_a) d15 = c;
            if (w1_fcp1)  s1++;
            if (w15_fcp1) s15++;
        end
        wreq = 0;
        checks++;
        if (g1 < 0 || d1 - g1 != 3 || s1 != 1) begin
            failures++;
            $display("FAIL pw1: grant=%0d done=%0d width=%0d, required done-grant=3 width=1", g1, d1, s1);
        end
        checks++;
        if (g15 < 0 || d15 - g15 != 17 || s15 != 15) begin
            failures++;
            $display("FAIL pw15: grant=%0d done=%0d width=%0d, required done-grant=17 width=15", g15, d15, s15);
        end
    endtask

    initial begin
        MR = 0; ff_clr = 0; wreq = 0;
        REQ_A = 0; REQ_B = 0; OP_A = 0; OP_B = 0;
        SEL_A = 0; SEL_B = 0; DAT_A = 0; DAT_B = 0;
        #2;
        test_reset();
        test_load();
        test_set_clear();
        test_alternate();
        test_toggle();
        test_mr_abort();
        test_random();
        test_pulse_widths();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
